// File: rtl/ahb_manager_pack.sv
// ahb_manager_pack
// Shared AHB encodings for the manager/subordinate blocks, plus the FSM state
// type of the memory subordinate and a byte-lane helper.
// No ports (package).
package ahb_manager_pack;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } t_htrans;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } t_hsize;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } t_hresp;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } t_hburst;

    typedef enum logic [2:0] {
        SUB_IDLE = 3'd0,
        SUB_WAIT = 3'd1,
        SUB_DATA = 3'd2,
        SUB_ERR1 = 3'd3,
        SUB_ERR2 = 3'd4
    } t_sub_state;

    localparam int WAIT_CNT_W = 4;

    // Byte-lane enables for a transfer of 2**size bytes starting at lane
    // 'offset' within a bus of up to 16 byte lanes.
    function automatic logic [15:0] lane_mask(input logic [3:0] offset,
                                              input logic [2:0] size);
        logic [15:0] ones;
        ones = (16'd1 << (5'd1 << size)) - 16'd1;
        return ones << offset;
    endfunction

endpackage

// File: rtl/ahb_sub_wait_gen.sv
// ahb_sub_wait_gen
// Per-beat wait-state generator. Supplies the wait count for the beat being
// accepted and a down-counter that flags the last wait cycle.
// Macro AHB_SUB_RAND_WAIT_EN: when defined, each beat's wait count is drawn
// from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) reduced to
// 0..WAIT_STATES; otherwise every beat uses exactly WAIT_STATES.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   start      in   legal transfer accepted this cycle
//   beat_wait  out  wait cycles for the beat being accepted
//   wait_last  out  current cycle is the last wait cycle
module ahb_sub_wait_gen
    import ahb_manager_pack::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [WAIT_CNT_W-1:0] beat_wait,
    output logic                  wait_last
);

    logic [WAIT_CNT_W-1:0] cnt;

`ifdef AHB_SUB_RAND_WAIT_EN
    logic [15:0] lfsr;
    logic        feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Advances once per accepted beat so every beat sees a fresh draw.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (start)
            lfsr <= {lfsr[14:0], feedback};
    end

    assign beat_wait = WAIT_CNT_W'(lfsr % 16'(WAIT_STATES + 1));
`else
    assign beat_wait = WAIT_CNT_W'(WAIT_STATES);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= beat_wait;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign wait_last = (cnt == WAIT_CNT_W'(1));

endmodule

// File: rtl/ahb_subordinate_mem.sv
// ahb_subordinate_mem
// AHB subordinate backed by an inferred register array. Checks alignment,
// size and range at the address phase, inserts configurable wait states,
// answers illegal transfers with the two-cycle ERROR response.
// Macro AHB_SUB_RAND_WAIT_EN (see ahb_sub_wait_gen) selects random per-beat
// wait counts; default build uses a fixed WAIT_STATES.
// Ports:
//   i_hclk, i_hreset       clock, synchronous active-high reset
//   i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst  address phase
//   i_hwdata               write data (data phase)
//   i_hready_in            bus-wide HREADY
//   o_hrdata, o_hready, o_hresp  data-phase response
//
// state    | meaning
// IDLE     | no transfer in data phase
// WAIT     | legal transfer accepted, inserting wait cycles
// DATA     | completing legal transfer (hready=1, OKAY)
// ERR1     | illegal transfer, first ERROR cycle (hready=0)
// ERR2     | illegal transfer, second ERROR cycle (hready=1)
module ahb_subordinate_mem
    import ahb_manager_pack::*;
#(
    parameter int DATA_WDT    = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  t_htrans             i_htrans,
    input  logic                i_hwrite,
    input  t_hsize              i_hsize,
    input  t_hburst             i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready_in,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output t_hresp              o_hresp
);

    localparam int NBYTES   = DATA_WDT / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    logic [DATA_WDT-1:0]   mem [MEM_DEPTH];

    t_sub_state            state, state_nxt;
    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_LSB-1:0]   off_q;
    t_hsize                size_q;
    logic                  write_q;
    logic [DATA_WDT-1:0]   rdata_q;

    logic                  can_accept, accept, legal, start;
    logic                  misaligned, too_wide, out_of_range;
    logic [WAIT_CNT_W-1:0] beat_wait;
    logic                  wait_last;
    logic [15:0]           lanes;
    logic [NBYTES-1:0]     byte_en;
    logic                  bus_unused;

    // A new address phase is only taken while the previous beat is completing.
    assign can_accept = (state == SUB_IDLE) || (state == SUB_DATA) || (state == SUB_ERR2);
    assign accept     = can_accept && i_hsel && i_hready_in &&
                        ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

    always_comb begin
        misaligned   = (i_haddr[7:0] & ((8'd1 << i_hsize) - 8'd1)) != 8'd0;
        too_wide     = (32'd8 << i_hsize) > 32'(DATA_WDT);
        out_of_range = (i_haddr >> ADDR_LSB) >= 32'(MEM_DEPTH);
        legal        = !(misaligned || too_wide || out_of_range);
    end

    assign start = accept && legal;

    ahb_sub_wait_gen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_gen (
        .clk       (i_hclk),
        .reset     (i_hreset),
        .start     (start),
        .beat_wait (beat_wait),
        .wait_last (wait_last)
    );

    always_ff @(posedge i_hclk) begin
        if (i_hreset)
            state <= SUB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SUB_IDLE, SUB_DATA, SUB_ERR2: begin
                if (!accept)
                    state_nxt = SUB_IDLE;
                else if (!legal)
                    state_nxt = SUB_ERR1;
                else if (beat_wait != '0)
                    state_nxt = SUB_WAIT;
                else
                    state_nxt = SUB_DATA;
            end
            SUB_WAIT: if (wait_last) state_nxt = SUB_DATA;
            SUB_ERR1: state_nxt = SUB_ERR2;
            default:  state_nxt = SUB_IDLE;
        endcase
    end

    // Writes commit on their DATA edge and reads always sit at least one cycle
    // behind, so reading the array directly already returns merged data.
    always_comb begin
        o_hready = !((state == SUB_WAIT) || (state == SUB_ERR1));
        o_hresp  = ((state == SUB_ERR1) || (state == SUB_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        o_hrdata = ((state == SUB_DATA) && !write_q) ? mem[idx_q] : rdata_q;
    end

    // rdata_q holds the last presented value so the bus stays stable while
    // hready is low; an illegal transfer clears it.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= HSIZE_BYTE;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                idx_q   <= i_haddr[ADDR_LSB +: IDX_W];
                off_q   <= i_haddr[ADDR_LSB-1:0];
                size_q  <= i_hsize;
                write_q <= i_hwrite;
            end
            if (accept && !legal)
                rdata_q <= '0;
            else if ((state == SUB_DATA) && !write_q)
                rdata_q <= mem[idx_q];
        end
    end

    assign lanes   = lane_mask(4'(off_q), size_q);
    assign byte_en = lanes[NBYTES-1:0];

    // No reset on the array; a reset edge suppresses any pending commit.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset && (state == SUB_DATA) && write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b])
                    mem[idx_q][b*8 +: 8] <= i_hwdata[b*8 +: 8];
            end
        end
    end

    assign bus_unused = ^{i_hburst, lanes};

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
module tb_ahb_subordinate_mem;
    import ahb_manager_pack::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel3;
    logic [31:0] haddr;
    t_htrans     htrans;
    logic        hwrite;
    t_hsize      hsize;
    t_hburst     hburst;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata3;
    logic        hready0, hready3;
    t_hresp      resp0, resp3;

    int n_cmp = 0;
    int n_err = 0;
    int low0  = 0;

    logic [31:0] rd;
    logic [1:0]  rf, rl;
    int          w;

    always #5 clk = ~clk;

    ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(sel0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready_in(hready0),
        .o_hrdata(rdata0), .o_hready(hready0), .o_hresp(resp0)
    );

    ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(sel3), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready_in(hready3),
        .o_hrdata(rdata3), .o_hready(hready3), .o_hresp(resp3)
    );

    always @(negedge clk) if (!hready0) low0++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single transfer followed by IDLE; reports data-phase wait cycles and
    // the response seen on the first and the completing data-phase cycle.
    task automatic xfer(input bit use3, input bit wr, input logic [31:0] addr,
                        input t_hsize size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] resp_first,
                        output logic [1:0] resp_last, output int waits);
        bit done;
        bit first;
        @(posedge clk) #1;
        sel0 = !use3; sel3 = use3;
        haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = size;
        @(posedge clk) #1;
        sel0 = 1'b0; sel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
        waits = 0; done = 1'b0; first = 1'b1;
        rdata = '0; resp_first = '0; resp_last = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (first) resp_first = use3 ? resp3 : resp0;
            first = 1'b0;
            if (use3 ? hready3 : hready0) begin
                rdata = use3 ? rdata3 : rdata0;
                resp_last = use3 ? resp3 : resp0;
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_hready0", 32'(hready0), 32'd1);
        check("rst_hresp0",  32'(resp0),   32'(HRESP_OKAY));
        check("rst_hrdata0", rdata0,       32'h0);
        check("rst_hready3", 32'(hready3), 32'd1);
        check("rst_hrdata3", rdata3,       32'h0);

        // Zero-wait write then read
        low0 = 0;
        xfer(1'b0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, rd, rf, rl, w);
        check("ws0_wr_resp",  32'(rl), 32'(HRESP_OKAY));
        check("ws0_wr_waits", 32'(w),  32'd0);
        xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("ws0_rd_data",  rd,      32'hDEADBEEF);
        check("ws0_rd_waits", 32'(w),  32'd0);
        check("ws0_no_low",   32'(low0), 32'd0);

        // Back-to-back write then read of the same word
        @(posedge clk) #1;
        sel0 = 1'b1; haddr = 32'h08; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk) #1;
        hwdata = 32'h0BADF00D; hwrite = 1'b0;
        @(posedge clk) #1;
        sel0 = 1'b0; htrans = HTRANS_IDLE;
        @(negedge clk);
        check("fwd_hready", 32'(hready0), 32'd1);
        check("fwd_data",   rdata0,       32'h0BADF00D);

        // Three wait states on inst3
        xfer(1'b1, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, rd, rf, rl, w);
        check("ws3_wr_waits", 32'(w), 32'd3);
        xfer(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("ws3_rd_waits",    32'(w),  32'd3);
        check("ws3_wait_resp",   32'(rf), 32'(HRESP_OKAY));
        check("ws3_rd_resp",     32'(rl), 32'(HRESP_OKAY));
        check("ws3_rd_data",     rd,      32'h11223344);

        // Byte write into lane 3; other lanes carry junk that must be ignored
        xfer(1'b1, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA555555, rd, rf, rl, w);
        xfer(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("byte_merge", rd, 32'hAA223344);

        // Misaligned halfword write
        xfer(1'b0, 1'b1, 32'h00, HSIZE_WORD, 32'hCAFEF00D, rd, rf, rl, w);
        xfer(1'b0, 1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, rd, rf, rl, w);
        check("mis_waits",  32'(w),  32'd1);
        check("mis_resp1",  32'(rf), 32'(HRESP_ERROR));
        check("mis_resp2",  32'(rl), 32'(HRESP_ERROR));
        check("mis_rdata",  rd,      32'h0);
        xfer(1'b0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("mis_mem",    rd,      32'hCAFEF00D);

        // Out-of-range read, then NONSEQ during ERR2
        @(posedge clk) #1;
        sel0 = 1'b1; haddr = 32'h400; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD;
        @(posedge clk) #1;
        sel0 = 1'b0; htrans = HTRANS_IDLE;
        @(negedge clk);
        check("oor_err1_hready", 32'(hready0), 32'd0);
        check("oor_err1_resp",   32'(resp0),   32'(HRESP_ERROR));
        @(posedge clk) #1;
        sel0 = 1'b1; haddr = 32'h10; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        @(negedge clk);
        check("oor_err2_hready", 32'(hready0), 32'd1);
        check("oor_err2_resp",   32'(resp0),   32'(HRESP_ERROR));
        @(posedge clk) #1;
        sel0 = 1'b0; htrans = HTRANS_IDLE;
        @(negedge clk);
        check("after_err_hready", 32'(hready0), 32'd1);
        check("after_err_resp",   32'(resp0),   32'(HRESP_OKAY));
        check("after_err_data",   rdata0,       32'hDEADBEEF);

        // Reset during WAIT of a write
        xfer(1'b1, 1'b1, 32'h20, HSIZE_WORD, 32'h12345678, rd, rf, rl, w);
        @(posedge clk) #1;
        sel3 = 1'b1; haddr = 32'h20; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk) #1;
        sel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_hready", 32'(hready3), 32'd1);
        check("rst_mid_resp",   32'(resp3),   32'(HRESP_OKAY));
        check("rst_mid_rdata",  rdata3,       32'h0);
        xfer(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("rst_mid_mem", rd, 32'h12345678);
        xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rf, rl, w);
        check("rst_keeps_mem", rd, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_subordinate_mem.md
AHB_SUBORDINATE_MEM -- requirements
Module: ahb_subordinate_mem

Interface
REQ-001 SHALL have parameter DATA_WDT, default 32, meaning data bus width in bits (32, 64 or 128).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning storage depth in DATA_WDT-wide words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning data-phase wait cycles per beat (0..15).
REQ-004 SHALL have ports, one clock and a synchronous active-high reset, as follows:
  i_hclk  in  1  clock, all logic on rising edge;
  i_hreset  in  1  synchronous active-high reset;
  i_hsel  in  1  subordinate select;
  i_haddr  in  32  byte address;
  i_htrans  in  2  t_htrans;
  i_hwrite  in  1  1 = write;
  i_hsize  in  3  t_hsize;
  i_hburst  in  3  t_hburst, accepted, not decoded;
  i_hwdata  in  DATA_WDT  write data;
  i_hready_in  in  1  bus-wide HREADY;
  o_hrdata  out  DATA_WDT  read data;
  o_hready  out  1  transfer done;
  o_hresp  out  2  t_hresp.

Function
REQ-005 SHALL accept an address phase only when i_hsel, i_hready_in and i_htrans is NONSEQ or SEQ.
REQ-006 SHALL answer IDLE/BUSY, or an unselected bus, with zero-wait OKAY.
REQ-007 SHALL use FSM states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-008 SHALL go IDLE->WAIT on an accepted legal transfer when WAIT_STATES>0, else IDLE->DATA.
REQ-009 SHALL count WAIT_STATES cycles in WAIT, then move to DATA.
REQ-010 SHALL, in DATA, drive o_hready=1 with OKAY, then accept back-to-back transfers (DATA->WAIT/DATA) or return to IDLE.
REQ-011 SHALL hold o_hready=0 and o_hresp=OKAY in WAIT.
REQ-012 SHALL treat a transfer as illegal when the address is misaligned to i_hsize, when 8<<i_hsize > DATA_WDT, or when the word index >= MEM_DEPTH.
REQ-013 SHALL respond to an illegal transfer with ERR1 (o_hready=0, ERROR) then ERR2 (o_hready=1, ERROR).
REQ-014 SHALL, on an illegal transfer, not write memory and drive o_hrdata=0.
REQ-015 SHALL ignore the address phase during ERR1 and accept a new one during ERR2.
REQ-016 SHALL, on a write, register the address phase and commit only the byte lanes selected by i_haddr low bits and i_hsize, using i_hwdata on the o_hready=1 cycle of DATA.
REQ-017 SHALL present read data on o_hrdata in the o_hready=1 cycle: full word, little-endian lane placement.
REQ-018 SHALL make a read immediately after a write to the same word return the merged new data, forwarding if required.
REQ-019 SHALL hold o_hrdata stable while o_hready=0.

Reset
REQ-020 SHALL, on i_hreset=1 at a clock edge, force FSM=IDLE, o_hready=1, o_hresp=OKAY, o_hrdata=0 and the wait counter to 0.
REQ-021 SHALL abort an in-flight transfer on reset mid-operation with no memory write.
REQ-022 SHALL leave memory contents unchanged by reset.

Configuration
REQ-023 SHALL, with AHB_SUB_RAND_WAIT_EN defined, draw each beat's wait count from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), range 0..WAIT_STATES.
REQ-024 SHALL, without AHB_SUB_RAND_WAIT_EN, use exactly WAIT_STATES and contain no LFSR logic.

Structure
REQ-025 SHALL use t_htrans, t_hsize, t_hresp and t_hburst from ahb_manager_pack.
REQ-026 SHALL add the FSM state enum t_sub_state to ahb_manager_pack.
REQ-027 SHALL place the wait counter and optional LFSR in sub-module ahb_sub_wait_gen.
REQ-028 SHALL keep storage as an inferred register array in the top module.

Verification
REQ-029 SHALL verify: WAIT_STATES=0, 32-bit write 0xDEADBEEF to 0x10 then read 0x10 -> read returns 0xDEADBEEF, o_hready never low.
REQ-030 SHALL verify: WAIT_STATES=3, single read -> exactly 3 cycles o_hready=0, then 1 cycle o_hready=1 with OKAY.
REQ-031 SHALL verify: byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read of 0x10 returns 0xAA223344.
REQ-032 SHALL verify: halfword access at 0x01 -> ERR1 then ERR2 (ERROR, o_hready 0 then 1), memory unchanged.
REQ-033 SHALL verify: address 4*MEM_DEPTH -> two-cycle ERROR; a NONSEQ issued during ERR2 completes OKAY.
REQ-034 SHALL verify: i_hreset=1 during WAIT of a write -> next cycle o_hready=1, OKAY, target word unchanged.
